ethernet_encapsulation: RTL and testbench
=========================================

ETHERNET_ENCAPSULATION -- requirements
Module: ethernet_encapsulation

Interface
REQ-001 SHALL have parameter destination_mac_addr, default 48'h023528fbdd66, the MAC sent in the destination field.
REQ-002 SHALL have parameter source_mac_addr, default 48'h072227acdb65, the MAC sent in the source field.
REQ-003 SHALL have parameter IFG_BYTES, default 12, the inter-frame gap length in cycles.
REQ-004 eth_tx_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 eth_rst  input  1  asynchronous, active-low reset.
REQ-006 eth_tx_en  input  1  transmit enable; sampled only in IDLE.
REQ-007 pct_qued  input  1  a complete packet is in the buffer (level).
REQ-008 pct_len  input  11  payload byte count; sampled on frame start.
REQ-009 ff_out_data_in  input  8  FWFT buffer head byte; valid in the cycle bf_in_r_en is high.
REQ-010 bf_in_r_en  output  1  pops one payload byte.
REQ-011 gmii_tx_d  output  8  GMII transmit data.
REQ-012 gmii_tx_en  output  1  GMII transmit enable.
REQ-013 gmii_tx_er  output  1  GMII transmit error; always driven 0.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 pct_txed  output  1  one-cycle pulse when the last FCS byte is driven.
REQ-016 len_err  output  1  one-cycle pulse when a packet is rejected.

Function
REQ-017 The FSM SHALL have the states IDLE, PREAMBLE, SFD, DEST, SRC, LEN, PAYLOAD, PAD, FCS and IFG.
REQ-018 The FSM SHALL leave IDLE when eth_tx_en=1 and pct_qued=1, latching pct_len in that cycle.
REQ-019 A latched pct_len above 1500 SHALL pulse len_err the next cycle and return to IDLE with no GMII activity and no bf_in_r_en.
REQ-020 All GMII outputs SHALL be registered; the first 0x55 appears with gmii_tx_en=1 one cycle after the start cycle.
REQ-021 The frame SHALL be sent in this order:
  - 7 bytes of 0x55, then 0xD5;
  - destination MAC, 6 bytes, MSB first;
  - source MAC, 6 bytes, MSB first;
  - pct_len as a 16-bit big-endian length field;
  - payload, then PAD bytes, then 4 FCS bytes.
REQ-022 gmii_tx_en SHALL be 1 on every frame byte and 0 otherwise.
REQ-023 bf_in_r_en SHALL be high for exactly pct_len cycles, each one cycle before the matching payload byte appears on gmii_tx_d.
REQ-024 pct_len=0 SHALL skip PAYLOAD, with no bf_in_r_en.
REQ-025 The FCS SHALL be computed as follows:
  - CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF;
  - covers destination through pad bytes;
  - the register is complemented and sent LSB byte first.
REQ-026 The CRC SHALL update one byte per cycle; computing it SHALL add no bubble between the last pad/payload byte and the first FCS byte.
REQ-027 IFG SHALL hold gmii_tx_en=0 and gmii_tx_d=0x00 for IFG_BYTES cycles, then return to IDLE.
REQ-028 Back-to-back packets SHALL start no earlier than the cycle after IFG completes.
REQ-029 Deasserting eth_tx_en or pct_qued mid-frame SHALL NOT abort the frame.
REQ-030 Byte counters SHALL be 11 bits wide; the PAD count is 46 - pct_len when pct_len < 46, else 0.

Reset
REQ-031 eth_rst=0 SHALL immediately force the following, at any time including mid-frame:
  - FSM to IDLE;
  - counters to 0 and CRC to 0xFFFFFFFF;
  - gmii_tx_d=0x00; gmii_tx_en, gmii_tx_er, bf_in_r_en, busy, pct_txed and len_err all 0.
REQ-032 After eth_rst rises, the first frame SHALL start no earlier than the first edge at which the REQ-018 start condition is met.

Configuration
REQ-033 Macro ETH_TX_PAD_EN defined: payloads shorter than 46 bytes SHALL be padded with 0x00 to 46 bytes.
REQ-034 Macro ETH_TX_PAD_EN undefined:
  - PAD is never entered;
  - pct_len < 46 is rejected exactly as REQ-019 (len_err pulse, no frame).

Verification
REQ-035 pct_len=46, payload 0x00..0x2D: 72 gmii_tx_en cycles; length field 0x00,0x2E; running CRC over bytes 8..71 (no final XOR) ends at 0xDEBB20E3; pct_txed pulses on byte 71; then 12 idle cycles.
REQ-036 pct_len=10 with ETH_TX_PAD_EN defined: 10 bytes read, 36 bytes of 0x00 sent, 72-cycle frame; with the macro undefined: len_err pulses once and gmii_tx_en stays 0.
REQ-037 pct_len=1501: len_err pulses once and bf_in_r_en, gmii_tx_en and busy all stay 0 after the pulse; pct_len=1500: a 1526-cycle frame.
REQ-038 eth_rst is pulled low during the 20th payload byte: all outputs are 0 in the same cycle; after release with pct_qued=1 and eth_tx_en=1, a full new preamble starts.
REQ-039 Two packets are queued back-to-back: 12 cycles of gmii_tx_en=0 separate the last FCS byte of the first frame from the first 0x55 of the second.

Source files
------------

// File: rtl/ethernet_encapsulation_if.sv
// Packet-buffer / GMII signal bundle for ethernet_encapsulation.
// slave: the encapsulator side; master: the packet source / GMII sink side.
interface ethernet_encapsulation_if;
  logic        eth_tx_en;
  logic        pct_qued;
  logic [10:0] pct_len;
  logic [7:0]  ff_out_data_in;
  logic        bf_in_r_en;
  logic [7:0]  gmii_tx_d;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic        pct_txed;
  logic        len_err;

  modport slave (
    input  eth_tx_en, pct_qued, pct_len, ff_out_data_in,
    output bf_in_r_en, gmii_tx_d, gmii_tx_en, gmii_tx_er, busy, pct_txed, len_err
  );

  modport master (
    output eth_tx_en, pct_qued, pct_len, ff_out_data_in,
    input  bf_in_r_en, gmii_tx_d, gmii_tx_en, gmii_tx_er, busy, pct_txed, len_err
  );
endinterface

// File: rtl/ethernet_encapsulation.sv
// Ethernet II framer: preamble/SFD, MACs, length, FWFT payload, pad, CRC-32 FCS, IFG.
// Define ETH_TX_PAD_EN to zero-pad short payloads to 46 bytes instead of rejecting them.
module ethernet_encapsulation #(
  parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
  parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
  parameter int unsigned IFG_BYTES            = 12
) (
  input  logic                    eth_tx_clk,
  input  logic                    eth_rst,
  ethernet_encapsulation_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DEST, SRC, LEN, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [10:0] MAX_LEN = 11'd1500;
  localparam logic [10:0] MIN_LEN = 11'd46;
  // The IDLE cycle in which the next start is sampled supplies the last gap cycle.
  localparam logic [10:0] IFG_LAST = (IFG_BYTES > 1) ? 11'(IFG_BYTES - 2) : '0;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [10:0] pad_q, pad_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        tx_en_q, tx_en_d;
  logic        txed_q, txed_d;
  logic        len_err_q, len_err_d;
  logic        len_bad;
  logic [10:0] pad_calc;
  logic [31:0] fcs_sh;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [10:0] idx);
    logic [47:0] sh;
    sh = mac << {idx, 3'b000};
    return sh[47:40];
  endfunction

  always_comb begin
    pad_calc = '0;
    len_bad  = (bus.pct_len > MAX_LEN);
`ifdef ETH_TX_PAD_EN
    if (bus.pct_len < MIN_LEN) pad_calc = MIN_LEN - bus.pct_len;
`else
    if (bus.pct_len < MIN_LEN) len_bad = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 11'd1;
    len_d     = len_q;
    pad_d     = pad_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.eth_tx_en && bus.pct_qued) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            state_d = PREAMBLE;
            len_d   = bus.pct_len;
            pad_d   = pad_calc;
          end
        end
      end
      PREAMBLE: if (cnt_q == 11'd6) begin state_d = SFD; cnt_d = '0; end
      SFD:      begin state_d = DEST; cnt_d = '0; end
      DEST:     if (cnt_q == 11'd5) begin state_d = SRC; cnt_d = '0; end
      SRC:      if (cnt_q == 11'd5) begin state_d = LEN; cnt_d = '0; end
      LEN: if (cnt_q == 11'd1) begin
        cnt_d   = '0;
        state_d = (len_q != '0) ? PAYLOAD : ((pad_q != '0) ? PAD : FCS);
      end
      PAYLOAD: if (cnt_q == len_q - 11'd1) begin
        cnt_d   = '0;
        state_d = (pad_q != '0) ? PAD : FCS;
      end
      PAD: if (cnt_q == pad_q - 11'd1) begin state_d = FCS; cnt_d = '0; end
      FCS: if (cnt_q == 11'd3) begin
        cnt_d   = '0;
        state_d = (IFG_BYTES > 1) ? IFG : IDLE;
      end
      IFG: if (cnt_q == IFG_LAST) begin state_d = IDLE; cnt_d = '0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  // Output bytes are decoded from the next state so the registered GMII lines
  // line up with the state register; the CRC folds in each byte as it is registered.
  always_comb begin
    tx_d_d  = '0;
    tx_en_d = 1'b1;
    crc_d   = crc_q;
    fcs_sh  = ~crc_q >> {cnt_d[1:0], 3'b000};
    case (state_d)
      PREAMBLE: tx_d_d = 8'h55;
      SFD:      tx_d_d = 8'hD5;
      DEST:     tx_d_d = mac_byte(destination_mac_addr, cnt_d);
      SRC:      tx_d_d = mac_byte(source_mac_addr, cnt_d);
      LEN:      tx_d_d = (cnt_d == '0) ? {5'b0, len_q[10:8]} : len_q[7:0];
      PAYLOAD:  tx_d_d = bus.ff_out_data_in;
      PAD:      tx_d_d = '0;
      FCS:      tx_d_d = fcs_sh[7:0];
      default: begin
        tx_en_d = 1'b0;
        crc_d   = '1;
      end
    endcase
    if (state_d inside {DEST, SRC, LEN, PAYLOAD, PAD}) crc_d = crc32_byte(crc_q, tx_d_d);
    txed_d = (state_d == FCS) && (cnt_d == 11'd3);
  end

  always_ff @(posedge eth_tx_clk or negedge eth_rst) begin
    if (!eth_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      pad_q     <= '0;
      crc_q     <= '1;
      tx_d_q    <= '0;
      tx_en_q   <= 1'b0;
      txed_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pad_q     <= pad_d;
      crc_q     <= crc_d;
      tx_d_q    <= tx_d_d;
      tx_en_q   <= tx_en_d;
      txed_q    <= txed_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.gmii_tx_d  = tx_d_q;
  assign bus.gmii_tx_en = tx_en_q;
  assign bus.gmii_tx_er = 1'b0;
  assign bus.pct_txed   = txed_q;
  assign bus.len_err    = len_err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.bf_in_r_en = (state_d == PAYLOAD);

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// Scoreboard bench for ethernet_encapsulation: expected frame bytes are queued at load
// time and popped as GMII bytes appear; a FWFT buffer model feeds the payload.
module tb_ethernet_encapsulation;
  localparam logic [47:0] DST = 48'h023528fbdd66;
  localparam logic [47:0] SRC = 48'h072227acdb65;
  localparam int IFG = 12;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ethernet_encapsulation_if bus();

  ethernet_encapsulation #(
    .destination_mac_addr(DST),
    .source_mac_addr(SRC),
    .IFG_BYTES(IFG)
  ) dut (
    .eth_tx_clk(clk),
    .eth_rst(rst_n),
    .bus(bus)
  );

  exp_t        exp_q[$];
  logic [7:0]  mem [0:4095];
  int          wr_idx = 0, rd_idx = 0;
  bit          pending = 0;
  int          total = 0, bad = 0;
  int          frames_done = 0, frame_len_last = 0, frame_pos = 0;
  int          idle_run = 0, last_gap = 0;
  int          bf_cnt = 0, lerr_cnt = 0, busy_cnt = 0, tx_cnt = 0;
  logic [31:0] rx_crc = 32'hFFFFFFFF;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    return e;
  endfunction

  task automatic load_packet(input int len, input int seed, input int mul);
    logic [31:0] c;
    logic [47:0] mac;
    logic [15:0] lf;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(8'h55, 1'b0));
    exp_q.push_back(mk(8'hD5, 1'b0));
    mac = DST;
    for (int i = 0; i < 6; i++) begin b = mac[47-8*i -: 8]; exp_q.push_back(mk(b, 1'b0)); c = crc_upd(c, b); end
    mac = SRC;
    for (int i = 0; i < 6; i++) begin b = mac[47-8*i -: 8]; exp_q.push_back(mk(b, 1'b0)); c = crc_upd(c, b); end
    lf = 16'(len);
    b = lf[15:8]; exp_q.push_back(mk(b, 1'b0)); c = crc_upd(c, b);
    b = lf[7:0];  exp_q.push_back(mk(b, 1'b0)); c = crc_upd(c, b);
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i * mul);
      mem[wr_idx % 4096] = b;
      wr_idx++;
      exp_q.push_back(mk(b, 1'b0));
      c = crc_upd(c, b);
    end
    for (int i = len; i < 46; i++) begin exp_q.push_back(mk(8'h00, 1'b0)); c = crc_upd(c, 8'h00); end
    c = ~c;
    for (int k = 0; k < 4; k++) begin b = c[8*k +: 8]; exp_q.push_back(mk(b, k == 3)); end
    bus.ff_out_data_in = mem[rd_idx % 4096];
  endtask

  task automatic start_pkt(input int len);
    @(posedge clk); #1;
    bus.eth_tx_en = 1'b1; bus.pct_qued = 1'b1; bus.pct_len = 11'(len);
    @(posedge clk); #1;
    bus.eth_tx_en = 1'b0; bus.pct_qued = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (frames_done >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({bus.gmii_tx_d, bus.gmii_tx_en, bus.gmii_tx_er, bus.bf_in_r_en, bus.busy, bus.pct_txed, bus.len_err} !== 14'h0) begin
      bad++; $display("FAIL reset_outputs: got d=%02h en=%b bf=%b busy=%b txed=%b lerr=%b want all 0",
                      bus.gmii_tx_d, bus.gmii_tx_en, bus.bf_in_r_en, bus.busy, bus.pct_txed, bus.len_err);
    end
    bus.eth_tx_en = 1'b1; bus.pct_qued = 1'b1; bus.pct_len = 11'd46;
    repeat (2) @(posedge clk);
    #1; total++;
    if (bus.busy !== 1'b0 || bus.gmii_tx_en !== 1'b0) begin
      bad++; $display("FAIL reset_hold: busy=%b en=%b want 0 0", bus.busy, bus.gmii_tx_en);
    end
    bus.eth_tx_en = 1'b0; bus.pct_qued = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_min_frame();
    int f0, b0, hi_in_gap, busy_err;
    bit ok;
    load_packet(46, 0, 1);
    f0 = frames_done; b0 = bf_cnt;
    start_pkt(46);
    total++;
    if (bus.gmii_tx_en !== 1'b1 || bus.gmii_tx_d !== 8'h55) begin
      bad++; $display("FAIL first_byte: got en=%b d=%02h want 1 55", bus.gmii_tx_en, bus.gmii_tx_d);
    end
    wait_frames(f0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL min_timeout: frames=%0d want %0d", frames_done, f0 + 1); end
    total++; if (frame_len_last !== 72) begin bad++; $display("FAIL min_len: got %0d want 72", frame_len_last); end
    total++; if (bf_cnt - b0 !== 46) begin bad++; $display("FAIL min_reads: got %0d want 46", bf_cnt - b0); end
    hi_in_gap = 0; busy_err = 0;
    for (int k = 0; k < IFG; k++) begin
      #2;
      if (bus.gmii_tx_en !== 1'b0) hi_in_gap++;
      if (bus.busy !== (k < IFG - 1)) busy_err++;
      @(posedge clk);
    end
    total++; if (hi_in_gap != 0) begin bad++; $display("FAIL min_ifg: en high %0d cycles want 0", hi_in_gap); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL min_ifg_busy: %0d wrong busy cycles want 0", busy_err); end
  endtask

`ifdef ETH_TX_PAD_EN
  task automatic test_pad();
    int lens[3] = '{10, 0, 45};
    int f0, b0;
    bit ok;
    foreach (lens[n]) begin
      load_packet(lens[n], 17 + n, 3);
      f0 = frames_done; b0 = bf_cnt;
      start_pkt(lens[n]);
      wait_frames(f0 + 1, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL pad_timeout: len=%0d", lens[n]); end
      total++; if (frame_len_last !== 72) begin bad++; $display("FAIL pad_len: len=%0d got %0d want 72", lens[n], frame_len_last); end
      total++; if (bf_cnt - b0 !== lens[n]) begin bad++; $display("FAIL pad_reads: got %0d want %0d", bf_cnt - b0, lens[n]); end
      repeat (IFG + 2) @(posedge clk);
    end
  endtask
`endif

  task automatic test_reject();
    int lens[$];
    int l0, b0, y0, t0;
    lens = '{1501, 2047};
`ifndef ETH_TX_PAD_EN
    lens.push_back(45); lens.push_back(10); lens.push_back(0);
`endif
    foreach (lens[n]) begin
      l0 = lerr_cnt; b0 = bf_cnt; y0 = busy_cnt; t0 = tx_cnt;
      start_pkt(lens[n]);
      total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL rej_pulse: len=%0d got %b want 1", lens[n], bus.len_err); end
      repeat (15) @(posedge clk);
      total++; if (lerr_cnt - l0 !== 1) begin bad++; $display("FAIL rej_count: len=%0d got %0d want 1", lens[n], lerr_cnt - l0); end
      total++;
      if (bf_cnt != b0 || busy_cnt != y0 || tx_cnt != t0) begin
        bad++; $display("FAIL rej_quiet: len=%0d reads=%0d busy=%0d tx=%0d want 0 0 0",
                        lens[n], bf_cnt - b0, busy_cnt - y0, tx_cnt - t0);
      end
    end
  endtask

  task automatic test_max_frame();
    int f0, b0;
    bit ok;
    load_packet(1500, 5, 1);
    f0 = frames_done; b0 = bf_cnt;
    start_pkt(1500);
    wait_frames(f0 + 1, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL max_timeout"); end
    total++; if (frame_len_last !== 1526) begin bad++; $display("FAIL max_len: got %0d want 1526", frame_len_last); end
    total++; if (bf_cnt - b0 !== 1500) begin bad++; $display("FAIL max_reads: got %0d want 1500", bf_cnt - b0); end
    repeat (IFG + 2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int f0, b0;
    bit ok;
    load_packet(60, 3, 5);
    start_pkt(60);
    repeat (41) @(posedge clk);
    #1; total++;
    if (bus.gmii_tx_en !== 1'b1 || bus.gmii_tx_d !== 8'h62) begin
      bad++; $display("FAIL mid_byte20: got en=%b d=%02h want 1 62", bus.gmii_tx_en, bus.gmii_tx_d);
    end
    rst_n = 1'b0;
    #1; total++;
    if ({bus.gmii_tx_d, bus.gmii_tx_en, bus.gmii_tx_er, bus.bf_in_r_en, bus.busy, bus.pct_txed, bus.len_err} !== 14'h0) begin
      bad++; $display("FAIL mid_reset: got d=%02h en=%b bf=%b busy=%b want all 0",
                      bus.gmii_tx_d, bus.gmii_tx_en, bus.bf_in_r_en, bus.busy);
    end
    exp_q.delete(); frame_pos = 0; rx_crc = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #2; pending = 0; rd_idx = wr_idx;
    rst_n = 1'b1;
    load_packet(50, 9, 3);
    f0 = frames_done; b0 = bf_cnt;
    start_pkt(50);
    wait_frames(f0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout"); end
    total++; if (frame_len_last !== 76) begin bad++; $display("FAIL mid_len: got %0d want 76", frame_len_last); end
    total++; if (bf_cnt - b0 !== 50) begin bad++; $display("FAIL mid_reads: got %0d want 50", bf_cnt - b0); end
    repeat (IFG + 2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int f0, b0;
    bit ok, seen;
    load_packet(50, 40, 7);
    load_packet(47, 90, 11);
    f0 = frames_done; b0 = bf_cnt;
    @(posedge clk); #1;
    bus.eth_tx_en = 1'b1; bus.pct_qued = 1'b1; bus.pct_len = 11'd50;
    @(posedge clk); #1;
    bus.pct_len = 11'd47;
    wait_frames(f0 + 1, 200, ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.gmii_tx_en === 1'b1) begin seen = 1'b1; break; end
    end
    bus.eth_tx_en = 1'b0; bus.pct_qued = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL b2b_second_start: no second frame"); end
    wait_frames(f0 + 2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: frames=%0d want %0d", frames_done, f0 + 2); end
    total++; if (last_gap !== IFG) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", last_gap, IFG); end
    total++; if (bf_cnt - b0 !== 97) begin bad++; $display("FAIL b2b_reads: got %0d want 97", bf_cnt - b0); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover: %0d bytes want 0", exp_q.size()); end
    repeat (IFG + 2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    bus.eth_tx_en = 1'b0; bus.pct_qued = 1'b0; bus.pct_len = '0; bus.ff_out_data_in = '0;
    fork
      forever begin
        @(negedge clk);
        total++;
        if (bus.gmii_tx_er !== 1'b0) begin bad++; $display("FAIL tx_er: got %b want 0", bus.gmii_tx_er); end
        if (bus.bf_in_r_en === 1'b1) begin bf_cnt++; pending = 1; end
        if (bus.len_err === 1'b1) lerr_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.gmii_tx_en === 1'b1) begin
          tx_cnt++;
          if (frame_pos == 0) last_gap = idle_run;
          idle_run = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_underflow: got byte %02h want no byte", bus.gmii_tx_d);
          end else begin
            e = exp_q.pop_front();
            if (bus.gmii_tx_d !== e.d || bus.pct_txed !== e.last) begin
              bad++; $display("FAIL sb_byte: pos=%0d got d=%02h txed=%b want d=%02h txed=%b",
                              frame_pos, bus.gmii_tx_d, bus.pct_txed, e.d, e.last);
            end
          end
          if (frame_pos >= 8) rx_crc = crc_upd(rx_crc, bus.gmii_tx_d);
          frame_pos++;
          if (bus.pct_txed === 1'b1) begin
            total++;
            if (rx_crc !== 32'hDEBB20E3) begin bad++; $display("FAIL crc_residue: got %08h want DEBB20E3", rx_crc); end
            frame_len_last = frame_pos; frame_pos = 0; rx_crc = 32'hFFFFFFFF; frames_done++;
          end
        end else begin
          idle_run++;
          total++;
          if (bus.gmii_tx_d !== 8'h00 || bus.pct_txed !== 1'b0) begin
            bad++; $display("FAIL idle_out: got d=%02h txed=%b want 00 0", bus.gmii_tx_d, bus.pct_txed);
          end
        end
      end
      forever begin
        @(posedge clk); #1;
        if (pending) begin pending = 0; rd_idx++; end
        bus.ff_out_data_in = mem[rd_idx % 4096];
      end
    join_none
    test_reset();
    test_min_frame();
`ifdef ETH_TX_PAD_EN
    test_pad();
`endif
    test_reject();
    test_max_frame();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
